// File: rtl/udp_tx_framer_if.sv
// udp_tx_framer_if: command, payload and MAC transmit stream signals of the UDP framer.
interface udp_tx_framer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_dst_mac;
    logic [31:0] cmd_dst_ip;
    logic [15:0] cmd_dst_port;
    logic [15:0] cmd_len;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [7:0]  tx_axis_tdata;
    logic        tx_axis_tvalid;
    logic        tx_axis_tready;
    logic        tx_axis_tlast;
    logic        tx_axis_tuser;
    modport master (
        input  cmd_valid, cmd_dst_mac, cmd_dst_ip, cmd_dst_port, cmd_len,
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, tx_axis_tready,
        output cmd_ready, s_axis_tready, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser
    );
    modport slave (
        output cmd_valid, cmd_dst_mac, cmd_dst_ip, cmd_dst_port, cmd_len,
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, tx_axis_tready,
        input  cmd_ready, s_axis_tready, tx_axis_tdata, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser
    );
endinterface

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: builds Ethernet II / IPv4 / UDP frames byte-serially for the MAC TX stream.
module udp_tx_framer #(
    parameter logic [47:0] SRC_MAC     = 48'h000A35000102,
    parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic            tx_axis_aclk,
    input  logic            reset,
    udp_tx_framer_if.master bus,
    output logic [15:0]     frame_count,
    output logic [15:0]     err_count
);
    typedef enum logic [2:0] {IDLE, CSUM, HDR, PAYLOAD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d, id_q, id_d, port_q, port_d, fc_q, fc_d, ec_q, ec_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;
    logic [19:0] acc_q, acc_d;
    logic [7:0]  tdata_q, tdata_d, hdr_byte;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d, init_q;
    logic        load, last_byte, cmd_rdy, s_rdy;
    logic [15:0] word;
    logic [159:0] words;
    logic [335:0] hdr;
    assign words = {16'h4500, 16'd28 + len_q, id_q, 16'h4000, 16'h4011, SRC_IP, ip_q, 16'h0000};
    assign hdr = {mac_q, SRC_MAC, 16'h0800, 16'h4500, 16'd28 + len_q, id_q, 16'h4000, 16'h4011,
                  ~acc_q[15:0], SRC_IP, ip_q, SRC_PORT, port_q, 16'd8 + len_q, 16'h0000};
    assign word = words[8'd144 - {cnt_q[3:0], 4'b0} +: 16];
    assign hdr_byte = hdr[10'd328 - {1'b0, cnt_q[5:0], 3'b0} +: 8];
    assign load = !tvalid_q || bus.tx_axis_tready;
    assign last_byte = cnt_q == len_q - 16'd1;
    // Holding off commands until the output register drains keeps frames strictly sequential.
    assign cmd_rdy = init_q && state_q == IDLE && !tvalid_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        len_d = len_q;
        id_d = id_q;
        port_d = port_q;
        mac_d = mac_q;
        ip_d = ip_q;
        acc_d = acc_q;
        fc_d = fc_q;
        ec_d = ec_q;
        tdata_d = tdata_q;
        tlast_d = tlast_q;
        tuser_d = tuser_q;
        tvalid_d = tvalid_q && !bus.tx_axis_tready;
        s_rdy = 1'b0;
        case (state_q)
            IDLE: if (bus.cmd_valid && cmd_rdy) begin
                if (bus.cmd_len > MAX_PAYLOAD) ec_d = ec_q + 16'd1;
                else begin
                    state_d = CSUM;
                    cnt_d = 16'd0;
                    acc_d = 20'd0;
                    mac_d = bus.cmd_dst_mac;
                    ip_d = bus.cmd_dst_ip;
                    port_d = bus.cmd_dst_port;
                    len_d = bus.cmd_len;
                end
            end
            CSUM: begin
                acc_d = cnt_q < 16'd10 ? acc_q + {4'b0, word} : {4'b0, acc_q[15:0]} + {16'b0, acc_q[19:16]};
                cnt_d = cnt_q + 16'd1;
                // The register is empty here, so header byte 0 loads in the last fold cycle.
                if (cnt_q == 16'd11) begin
                    state_d = HDR;
                    cnt_d = 16'd1;
                    tvalid_d = 1'b1;
                    tdata_d = mac_q[47:40];
                    tlast_d = 1'b0;
                    tuser_d = 1'b0;
                end
            end
            HDR: if (load) begin
                tvalid_d = 1'b1;
                tdata_d = hdr_byte;
                tlast_d = cnt_q == 16'd41 && len_q == 16'd0;
                tuser_d = 1'b0;
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd41) begin
                    cnt_d = 16'd0;
                    state_d = len_q == 16'd0 ? IDLE : PAYLOAD;
                    fc_d = len_q == 16'd0 ? fc_q + 16'd1 : fc_q;
                    id_d = len_q == 16'd0 ? id_q + 16'd1 : id_q;
                end
            end
            PAYLOAD: begin
                s_rdy = load;
                if (load && bus.s_axis_tvalid) begin
                    tvalid_d = 1'b1;
                    tdata_d = bus.s_axis_tdata;
                    tlast_d = bus.s_axis_tlast || last_byte;
                    tuser_d = bus.s_axis_tlast != last_byte;
                    cnt_d = cnt_q + 16'd1;
                    if (tlast_d) begin
                        id_d = id_q + 16'd1;
                        fc_d = tuser_d ? fc_q : fc_q + 16'd1;
                        ec_d = tuser_d ? ec_q + 16'd1 : ec_q;
                        state_d = bus.s_axis_tlast ? IDLE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                s_rdy = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge tx_axis_aclk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            len_q <= '0;
            id_q <= '0;
            port_q <= '0;
            mac_q <= '0;
            ip_q <= '0;
            acc_q <= '0;
            fc_q <= '0;
            ec_q <= '0;
            tdata_q <= '0;
            tvalid_q <= 1'b0;
            tlast_q <= 1'b0;
            tuser_q <= 1'b0;
            init_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            id_q <= id_d;
            port_q <= port_d;
            mac_q <= mac_d;
            ip_q <= ip_d;
            acc_q <= acc_d;
            fc_q <= fc_d;
            ec_q <= ec_d;
            tdata_q <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q <= tlast_d;
            tuser_q <= tuser_d;
            init_q <= 1'b1;
        end
    end
    assign bus.cmd_ready = cmd_rdy;
    assign bus.s_axis_tready = s_rdy;
    assign bus.tx_axis_tdata = tdata_q;
    assign bus.tx_axis_tvalid = tvalid_q;
    assign bus.tx_axis_tlast = tlast_q;
    assign bus.tx_axis_tuser = tuser_q;
    assign frame_count = fc_q;
    assign err_count = ec_q;
endmodule
